// File: rtl/cannon_pkg.sv
// Shared definitions for the Cannon array: element width, step FSM states and
// the sub-block packing offset used by both the distributor/shifter and the MAC.
package cannon_pkg;

    localparam int DW = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Bit offset of element [r][c] in a row-major packed sub-block.
    function automatic int idx(input int r, input int c, input int blk);
        return (r * blk + c) * DW;
    endfunction

endpackage

// File: rtl/pe_mac_unit.sv
// Combinational multiply-add, acc + a*b wrapped to DW bits.
module pe_mac_unit import cannon_pkg::*; #(
    parameter int DW = cannon_pkg::DW
) (
    input  logic [DW-1:0] acc,
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    output logic [DW-1:0] sum
);

    logic [DW-1:0] prod;

    // Low DW bits are identical for signed and unsigned operands.
    assign prod = a * b;
    assign sum  = acc + prod;

endmodule

// File: rtl/cannon_block_mac.sv
// Per-processor Cannon compute stage: accumulates A*B into a local C sub-block
// using one multiply-add per cycle, BLK^3 cycles per step.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | waiting for start; C is final and stable
//   MAC   | one C[i][j] += A[i][k]*B[k][j] per edge, k fastest, i slowest
//   DONE  | done pulse for one cycle, then back to IDLE
module cannon_block_mac import cannon_pkg::*; #(
    parameter int BLK = 2,
    parameter int DW  = cannon_pkg::DW
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  clear_acc,
    input  logic [BLK*BLK*DW-1:0] a_blk,
    input  logic [BLK*BLK*DW-1:0] b_blk,
    output logic [BLK*BLK*DW-1:0] c_blk,
    output logic                  busy,
    output logic                  done
);

    localparam int NW = BLK * BLK * DW;
    localparam int CW = (BLK > 1) ? $clog2(BLK) : 1;
    localparam logic [CW-1:0] LAST = CW'(BLK - 1);

    state_e        state_q, state_d;
    logic [CW-1:0] i_q, i_d;
    logic [CW-1:0] j_q, j_d;
    logic [CW-1:0] k_q, k_d;
    logic [NW-1:0] a_q, a_d;
    logic [NW-1:0] b_q, b_d;
    logic [NW-1:0] c_q, c_d;

    logic [DW-1:0] acc_el, a_el, b_el, sum_el;

    function automatic int off(input int r, input int c);
        return (r * BLK + c) * DW;
    endfunction

    assign acc_el = c_q[off(int'(i_q), int'(j_q)) +: DW];
    assign a_el   = a_q[off(int'(i_q), int'(k_q)) +: DW];
    assign b_el   = b_q[off(int'(k_q), int'(j_q)) +: DW];

    pe_mac_unit #(.DW(DW)) u_mac (
        .acc (acc_el),
        .a   (a_el),
        .b   (b_el),
        .sum (sum_el)
    );

    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        j_d     = j_q;
        k_d     = k_q;
        a_d     = a_q;
        b_d     = b_q;
        c_d     = c_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    // Operands are latched so upstream can shift right away.
                    a_d     = a_blk;
                    b_d     = b_blk;
                    if (clear_acc) c_d = '0;
                    i_d     = '0;
                    j_d     = '0;
                    k_d     = '0;
                    state_d = MAC;
                end
            end
            MAC: begin
                c_d[off(int'(i_q), int'(j_q)) +: DW] = sum_el;
                if (k_q != LAST) begin
                    k_d = k_q + 1'b1;
                end else begin
                    k_d = '0;
                    if (j_q != LAST) begin
                        j_d = j_q + 1'b1;
                    end else begin
                        j_d = '0;
                        if (i_q != LAST) begin
                            i_d = i_q + 1'b1;
                        end else begin
                            i_d     = '0;
                            state_d = DONE;
                        end
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            i_q     <= '0;
            j_q     <= '0;
            k_q     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= '0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            k_q     <= k_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
        end
    end

    assign c_blk = c_q;
    assign busy  = (state_q != IDLE);
    assign done  = (state_q == DONE);

endmodule

// File: tb/tb_cannon_block_mac.sv
// Directed bench for cannon_block_mac (BLK=2, DW=32) with a result scoreboard.
module tb_cannon_block_mac;

    localparam int BLK = 2;
    localparam int DW  = 32;
    localparam int NW  = BLK * BLK * DW;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic          clear_acc;
    logic [NW-1:0] a_blk;
    logic [NW-1:0] b_blk;
    logic [NW-1:0] c_blk;
    logic          busy;
    logic          done;

    int checks   = 0;
    int failures = 0;

    logic [NW-1:0] exp_q[$];
    logic [NW-1:0] model_c;

    cannon_block_mac #(.BLK(BLK), .DW(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .clear_acc (clear_acc),
        .a_blk     (a_blk),
        .b_blk     (b_blk),
        .c_blk     (c_blk),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [NW-1:0] mk(input logic [31:0] e00, input logic [31:0] e01,
                                         input logic [31:0] e10, input logic [31:0] e11);
        return {e11, e10, e01, e00};
    endfunction

    function automatic logic [NW-1:0] mac_model(input logic [NW-1:0] c,
                                                input logic [NW-1:0] a,
                                                input logic [NW-1:0] b);
        logic [NW-1:0] r;
        logic [31:0]   acc;
        logic [31:0]   ae, be;
        r = c;
        for (int i = 0; i < BLK; i++) begin
            for (int j = 0; j < BLK; j++) begin
                acc = c[(i*BLK+j)*DW +: DW];
                for (int k = 0; k < BLK; k++) begin
                    ae  = a[(i*BLK+k)*DW +: DW];
                    be  = b[(k*BLK+j)*DW +: DW];
                    acc = acc + ae * be;
                end
                r[(i*BLK+j)*DW +: DW] = acc;
            end
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [NW-1:0] obs, input logic [NW-1:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full step; inject=1 also tries a mid-step start and a_blk corruption.
    task automatic do_step(input string tag, input logic [NW-1:0] a, input logic [NW-1:0] b,
                           input logic clr, input logic inject);
        int dones;
        int done_cyc;
        logic [NW-1:0] expv;
        if (clr) model_c = '0;
        model_c = mac_model(model_c, a, b);
        exp_q.push_back(model_c);
        a_blk     = a;
        b_blk     = b;
        clear_acc = clr;
        start     = 1'b1;
        tick();
        start     = 1'b0;
        clear_acc = 1'b0;
        dones     = 0;
        done_cyc  = 0;
        for (int cyc = 1; cyc <= 20; cyc++) begin
            if (cyc == 1) check({tag, "_busy_c1"}, NW'(busy), NW'(1'b1));
            if (inject && cyc == 2) a_blk = '1;
            start = (inject && cyc == 3);
            if (done) begin
                dones++;
                if (dones == 1) done_cyc = cyc;
                if (exp_q.size() == 0) begin
                    check({tag, "_sb_empty"}, NW'(1'b1), NW'(1'b0));
                end else begin
                    expv = exp_q.pop_front();
                    check({tag, "_c_at_done"}, c_blk, expv);
                end
            end
            tick();
        end
        start = 1'b0;
        check({tag, "_done_count"}, NW'(dones), NW'(1));
        check({tag, "_done_cycle"}, NW'(done_cyc), NW'(9));
        check({tag, "_idle_busy"}, NW'(busy), NW'(1'b0));
        check({tag, "_c_idle"}, c_blk, model_c);
    endtask

    initial begin
        int ab_dones;
        rst_n     = 1'b0;
        start     = 1'b0;
        clear_acc = 1'b0;
        a_blk     = '0;
        b_blk     = '0;
        model_c   = '0;
        tick();
        tick();
        check("rst_c", c_blk, '0);
        check("rst_busy", NW'(busy), NW'(1'b0));
        check("rst_done", NW'(done), NW'(1'b0));
        rst_n = 1'b1;

        clear_acc = 1'b1;
        tick();
        check("clear_alone_busy", NW'(busy), NW'(1'b0));
        clear_acc = 1'b0;

        do_step("ident", mk(1, 0, 0, 1), mk(1, 2, 3, 4), 1'b1, 1'b0);
        check("ident_const", c_blk, mk(1, 2, 3, 4));

        do_step("accum", mk(1, 2, 3, 4), mk(5, 6, 7, 8), 1'b0, 1'b0);
        check("accum_const", c_blk, mk(20, 24, 46, 54));

        do_step("wrap", mk(32'hFFFF_FFFF, 0, 0, 0), mk(32'hFFFF_FFFF, 0, 0, 0), 1'b1, 1'b0);
        check("wrap_const", c_blk, mk(1, 0, 0, 0));

        do_step("ignore", mk(2, 1, 0, 3), mk(4, 0, 5, 1), 1'b1, 1'b1);

        // Abort mid-MAC with a synchronous reset.
        a_blk     = mk(7, 7, 7, 7);
        b_blk     = mk(3, 3, 3, 3);
        clear_acc = 1'b1;
        start     = 1'b1;
        tick();
        start     = 1'b0;
        clear_acc = 1'b0;
        tick();
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("abort_busy", NW'(busy), NW'(1'b0));
        check("abort_done", NW'(done), NW'(1'b0));
        check("abort_c", c_blk, '0);
        ab_dones = 0;
        for (int cyc = 0; cyc < 12; cyc++) begin
            if (done) ab_dones++;
            tick();
        end
        check("abort_no_done", NW'(ab_dones), NW'(0));
        model_c = '0;

        do_step("post_abort", mk(1, 2, 3, 4), mk(1, 1, 1, 1), 1'b1, 1'b0);
        check("sb_drained", NW'(exp_q.size()), NW'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cannon_block_mac.md
Name: cannon_block_mac

Overview:
- Per-processor compute stage of the Cannon matrix-multiply array. Sits directly downstream of the block distributor/shifter, which owns the A/B sub-block registers and the right/down shifts.
- Once per Cannon step it consumes one A sub-block and one B sub-block and accumulates their product into a local C sub-block.
- Uses a single time-multiplexed multiply-add datapath, BLK^3 cycles per step.
- Reports completion with a one-cycle done pulse, so the controller can trigger the next shift.

Parameters:
- BLK, 2, sub-block edge (n / sqrt(p)); must be >= 1.
- DW, 32, element width in bits; elements are two's-complement integers.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset, sampled on the rising edge of clk.
- start  in  1  request one accumulation step; sampled only in IDLE.
- clear_acc  in  1  sampled together with an accepted start; 1 = zero C before the step.
- a_blk  in  BLK*BLK*DW  A sub-block, row-major; element [r][c] at bits [(r*BLK+c)*DW +: DW].
- b_blk  in  BLK*BLK*DW  B sub-block, same packing as a_blk.
- c_blk  out  BLK*BLK*DW  registered C accumulator, same packing as a_blk.
- busy  out  1  high in MAC and DONE states.
- done  out  1  one-cycle pulse when the step is complete.

Behaviour:
- Reset (rst_n=0 at an edge):
  - state=IDLE; every c_blk element=0; busy=0; done=0; all counters=0.
  - Applies from any state, including mid-MAC; the aborted step produces no done.
- FSM states: IDLE -> MAC -> DONE -> IDLE.
- IDLE:
  - At an edge with start=1: capture a_blk and b_blk into internal operand registers; if clear_acc=1, zero all of C in the same edge; go to MAC with i=j=k=0.
  - At an edge with start=0: no change; clear_acc alone has no effect.
- MAC, one product per edge:
  - Update: C[i][j] <= C[i][j] + A[i][k]*B[k][j], using the captured operands.
  - Product and sum are truncated to the low DW bits (wrap modulo 2^DW, no saturation).
  - Loop order: k innermost, then j, then i outermost.
  - After the edge with i=j=k=BLK-1, go to DONE.
- DONE: done=1 for exactly this cycle; the next edge goes to IDLE.
- Latency:
  - done is high in the (BLK^3+1)-th cycle after the start edge; for BLK=2 that is cycle 9.
  - The earliest next start is sampled at the edge that leaves DONE +1, i.e. in IDLE.
  - A start held high continuously starts a new step every BLK^3+2 cycles.
- Boundary rules:
  - start while busy is ignored and not queued.
  - a_blk/b_blk changes after the start edge do not affect the step; upstream may shift immediately after acceptance.
  - c_blk elements may be observed mid-step as partial sums; c_blk is final only while done=1 and in IDLE.
  - BLK=1: one MAC cycle, done in cycle 2.

Decomposition:
- Package cannon_pkg:
  - DW constant.
  - State enum {IDLE, MAC, DONE}.
  - Element-offset function idx(r, c, blk) returning (r*blk+c)*DW.
  - Shared with the distributor/shifter for identical packing.
- Sub-module pe_mac_unit: combinational acc + a*b, truncated to DW bits. Instantiated once and reused for a later pipelined variant.

Test Plan:
- Reset: hold rst_n=0 for 2 edges -> c_blk=0, busy=0, done=0.
- Identity, BLK=2: A=I, B=[1 2;3 4], start+clear_acc -> busy next cycle, done only in cycle 9, C=[1 2;3 4].
- Accumulate: after the identity step, start without clear, A=[1 2;3 4], B=[5 6;7 8] -> C=[20 24;46 54].
- Wrap: A=B=diag(0xFFFFFFFF,0), start+clear -> C[0][0]=0x00000001, other elements 0.
- Ignore rules: pulse start at cycle 3 of a step and change a_blk to all 0xFF at cycle 2 -> result unchanged, exactly one done.
- Abort: rst_n=0 at MAC cycle 4 -> next cycle IDLE, C=0, no done; a following start+clear step completes normally.
